// File: rtl/reservation_station.sv
// Reservation-station bank: holds issued ops, snoops the CDB for pending operands and
// dispatches the lowest-index ready entry to the attached functional unit.
package types;
  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] variant;
  } operation_specification;

  typedef struct packed {
    logic        is_virtual;
    logic [63:0] data;
  } register;

  typedef struct packed {
    logic                   valid;
    logic [2:0]             rs_id;
    operation_specification op;
  } issue_bus;
endpackage

module reservation_station #(
  parameter int NUM_ENTRIES = 2,
  parameter int BASE_ID     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  types::issue_bus              issue,
  input  types::register               issue_src1,
  input  types::register               issue_src2,
  output logic [NUM_ENTRIES-1:0]       busy,
  input  logic                         cdb_valid,
  input  logic [2:0]                   cdb_rs_id,
  input  logic [63:0]                  cdb_value,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [2:0]                   disp_rs_id,
  output types::operation_specification disp_op,
  output logic [63:0]                  disp_a,
  output logic [63:0]                  disp_b,
  output logic [2*NUM_ENTRIES-1:0]     dbg_state_o
);
  // Handshake: the FU takes an op at a rising edge where disp_valid && disp_ready; once
  // disp_valid is raised the presented entry stays put until that edge.
  typedef enum logic [1:0] {E_FREE = 2'd0, E_WAIT = 2'd1, E_READY = 2'd2} entry_state_e;

  entry_state_e                  state_q [NUM_ENTRIES];
  entry_state_e                  state_d [NUM_ENTRIES];
  types::operation_specification op_q    [NUM_ENTRIES];
  types::operation_specification op_d    [NUM_ENTRIES];
  logic [63:0]                   a_q     [NUM_ENTRIES];
  logic [63:0]                   a_d     [NUM_ENTRIES];
  logic [63:0]                   b_q     [NUM_ENTRIES];
  logic [63:0]                   b_d     [NUM_ENTRIES];
  logic [2:0]                    a_tag_q [NUM_ENTRIES];
  logic [2:0]                    a_tag_d [NUM_ENTRIES];
  logic [2:0]                    b_tag_q [NUM_ENTRIES];
  logic [2:0]                    b_tag_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]        a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic [NUM_ENTRIES-1:0]        lock_oh_q, lock_oh_d;
  logic [NUM_ENTRIES-1:0]        sel_oh, issue_hit;
  logic                          accept, issue_to_busy;

  function automatic logic [64:0] capture(types::register src, logic cv, logic [2:0] ct,
                                          logic [63:0] cval);
    if (!src.is_virtual) return {1'b1, src.data};
    if (cv && ct == src.data[2:0]) return {1'b1, cval};
    return {1'b0, 64'd0};
  endfunction

  // A held (locked) entry wins over any lower index that became ready later.
  always_comb begin
    sel_oh     = '0;
    disp_valid = 1'b0;
    disp_rs_id = '0;
    disp_op    = '0;
    disp_a     = '0;
    disp_b     = '0;
    if (|lock_oh_q) begin
      sel_oh = lock_oh_q;
    end else begin
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
        if (state_q[i] == E_READY) begin
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
        end
      end
    end
    disp_valid = |sel_oh;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel_oh[i]) begin
        disp_rs_id = 3'(BASE_ID + i);
        disp_op    = op_q[i];
        disp_a     = a_q[i];
        disp_b     = b_q[i];
      end
    end
  end

  assign accept    = disp_valid && disp_ready;
  assign lock_oh_d = accept ? '0 : sel_oh;

  always_comb begin
    busy          = '0;
    issue_hit     = '0;
    issue_to_busy = 1'b0;
    dbg_state_o   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy[i]                = (state_q[i] != E_FREE);
      dbg_state_o[2*i +: 2]  = state_q[i];
      if (issue.valid && issue.rs_id == 3'(BASE_ID + i)) begin
        issue_hit[i]  = (state_q[i] == E_FREE);
        issue_to_busy = issue_to_busy | (state_q[i] != E_FREE);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    a_tag_d = a_tag_q;
    b_tag_d = b_tag_q;
    a_rdy_d = a_rdy_q;
    b_rdy_d = b_rdy_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      case (state_q[i])
        E_FREE: begin
          if (issue_hit[i]) begin
            op_d[i]                = issue.op;
            a_tag_d[i]             = issue_src1.data[2:0];
            b_tag_d[i]             = issue_src2.data[2:0];
            {a_rdy_d[i], a_d[i]}   = capture(issue_src1, cdb_valid, cdb_rs_id, cdb_value);
            {b_rdy_d[i], b_d[i]}   = capture(issue_src2, cdb_valid, cdb_rs_id, cdb_value);
            state_d[i]             = (a_rdy_d[i] && b_rdy_d[i]) ? E_READY : E_WAIT;
          end
        end
        E_WAIT: begin
          if (!a_rdy_q[i] && cdb_valid && cdb_rs_id == a_tag_q[i]) begin
            a_d[i]     = cdb_value;
            a_rdy_d[i] = 1'b1;
          end
          if (!b_rdy_q[i] && cdb_valid && cdb_rs_id == b_tag_q[i]) begin
            b_d[i]     = cdb_value;
            b_rdy_d[i] = 1'b1;
          end
          if (a_rdy_d[i] && b_rdy_d[i]) state_d[i] = E_READY;
        end
        E_READY: begin
          if (accept && sel_oh[i]) begin
            state_d[i] = E_FREE;
            a_rdy_d[i] = 1'b0;
            b_rdy_d[i] = 1'b0;
          end
        end
        default: state_d[i] = E_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= E_FREE;
        op_q[i]    <= '0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        a_tag_q[i] <= '0;
        b_tag_q[i] <= '0;
      end
      a_rdy_q   <= '0;
      b_rdy_q   <= '0;
      lock_oh_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_tag_q   <= a_tag_d;
      b_tag_q   <= b_tag_d;
      a_rdy_q   <= a_rdy_d;
      b_rdy_q   <= b_rdy_d;
      lock_oh_q <= lock_oh_d;
    end
  end

  // The issue unit must never target an occupied entry.
  assert property (@(posedge clk) disable iff (rst) !issue_to_busy);

endmodule
